jpeg_byte_unstuffer: RTL
========================

JPEG_BYTE_UNSTUFFER -- requirements
Module: jpeg_byte_unstuffer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = byte 0 of a word is in_data[31:24], 0 = byte 0 is in_data[7:0].
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  32  packed JPEG stream word.
REQ-005 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-006 SHALL have port upstream_stall  output  1  high = in_data not accepted this cycle.
REQ-007 SHALL have port out_byte  output  8  unstuffed byte.
REQ-008 SHALL have port out_marker  output  1  high = out_byte is a marker code (byte that followed 0xFF).
REQ-009 SHALL have port out_valid  output  1  out_byte/out_marker valid.
REQ-010 SHALL have port downstream_stall  input  1  high = consumer not taking the output this cycle.

Function
REQ-011 SHALL hold one 32-bit word buffer, a 2-bit byte index and a buffer-valid flag.
REQ-012 SHALL capture in_data at an edge where in_valid && !upstream_stall: index to 0, buffer-valid to 1.
REQ-013 SHALL define advance = !out_valid || !downstream_stall; the output register loads only on advance.
REQ-014 SHALL consume one buffered byte per advance cycle, whether or not that byte produces output.
REQ-015 SHALL drive upstream_stall = buffer-valid && !(advance && index==3), so back-to-back words stream with no bubble.
REQ-016 SHALL clear buffer-valid after consuming byte 3 unless a new word is captured on the same edge.
REQ-017 SHALL run an unstuffing FSM with states NORMAL and SAW_FF; state persists across word boundaries.
REQ-018 In NORMAL, byte != 0xFF: SHALL emit byte (marker=0) and stay in NORMAL.
REQ-019 In NORMAL, byte == 0xFF: SHALL emit nothing and go to SAW_FF.
REQ-020 In SAW_FF, byte == 0x00: SHALL emit 0xFF (marker=0) and go to NORMAL.
REQ-021 In SAW_FF, byte == 0xFF: SHALL emit nothing (fill byte) and stay in SAW_FF.
REQ-022 In SAW_FF, any other byte: SHALL emit that byte with marker=1 and go to NORMAL.
REQ-023 On an advance cycle with no byte emitted, SHALL load out_valid=0.
REQ-024 While out_valid && downstream_stall, SHALL hold out_byte, out_marker and out_valid stable and hold FSM state and index.
REQ-025 Latency: byte 0 of a word captured at edge N SHALL appear at edge N+1; byte k at edge N+1+k, absent stalls.
REQ-026 Throughput: SHALL sustain one consumed byte per clock while downstream_stall is low.
REQ-027 SHALL never drop, duplicate or reorder emitted bytes under any stall pattern.

Reset
REQ-028 On reset SHALL set out_byte=0, out_marker=0, out_valid=0, buffer-valid=0, index=0 and FSM=NORMAL.
REQ-029 SHALL discard any partially consumed word or pending SAW_FF state when reset is asserted mid-operation.
REQ-030 SHALL drive upstream_stall=0 in the first cycle after reset deasserts.

Verification
REQ-031 MSB_FIRST=1, word 0x12345678, no stall -> 0x12,0x34,0x56,0x78 on 4 consecutive cycles, marker=0.
REQ-032 Word 0xAAFF00BB -> exactly 0xAA,0xFF,0xBB, all with marker=0; one cycle with out_valid=0.
REQ-033 Words 0x112233FF then 0xD9445566 back-to-back -> 0x11,0x22,0x33, then 0xD9 marker=1, then 0x44,0x55,0x66.
REQ-034 Word 0xFFFFFFD8 -> single output 0xD8 marker=1.
REQ-035 Continuous words with downstream_stall high for 3 cycles while out_valid=1 -> output held; upstream_stall=1 with buffer full; full byte sequence intact afterwards.
REQ-036 Word 0x5566 77FF, reset asserted after 0xFF consumed, then word 0x00112233 -> 0x00,0x11,0x22,0x33 as data, marker=0.

Source files
------------

// File: rtl/jpeg_byte_unstuffer.sv
// jpeg_byte_unstuffer
// Splits packed 32-bit JPEG entropy-stream words into bytes, removes 0xFF00
// byte stuffing and 0xFF fill bytes, and flags the code byte that follows an
// 0xFF as a marker. One byte is consumed per clock whenever the output
// register is free. The SAW_FF state carries across word boundaries.
module jpeg_byte_unstuffer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        upstream_stall,
    output logic [7:0]  out_byte,
    output logic        out_marker,
    output logic        out_valid,
    input  logic        downstream_stall
);

    typedef enum logic {
        NORMAL = 1'b0,
        SAW_FF = 1'b1
    } state_e;

    // Word buffer and read pointer
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        buf_valid_q, buf_valid_d;

    // Unstuffing state
    state_e      state_q, state_d;

    // Output register
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_marker_q, out_marker_d;
    logic        out_valid_q, out_valid_d;

    // Handshake terms
    logic        advance;
    logic        consume;
    logic        last_byte;
    logic        accept;

    // Current byte and its decode
    logic [1:0]  lane;
    logic [7:0]  cur_byte;
    logic        emit;
    logic [7:0]  emit_byte;
    logic        emit_marker;
    state_e      state_after;

    // Output register is free, or its contents are being taken this cycle
    always_comb begin
        advance        = !out_valid_q || !downstream_stall;
        consume        = buf_valid_q && advance;
        last_byte      = (idx_q == 2'd3);
        // Accept a new word on the same edge that the last buffered byte
        // is consumed, so consecutive words stream without a bubble.
        upstream_stall = buf_valid_q && !(advance && last_byte);
        accept         = in_valid && !upstream_stall;
    end

    // Map the byte index onto a physical byte lane of the buffered word
    always_comb begin
        lane = (MSB_FIRST != 1'b0) ? (2'd3 - idx_q) : idx_q;
        unique case (lane)
            2'd0:    cur_byte = word_q[7:0];
            2'd1:    cur_byte = word_q[15:8];
            2'd2:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
        endcase
    end

    // Unstuffing decode of the current byte given the FSM state
    always_comb begin
        emit        = 1'b0;
        emit_byte   = cur_byte;
        emit_marker = 1'b0;
        state_after = state_q;
        unique case (state_q)
            NORMAL: begin
                if (cur_byte == 8'hFF) begin
                    state_after = SAW_FF;
                end else begin
                    emit = 1'b1;
                end
            end
            SAW_FF: begin
                if (cur_byte == 8'h00) begin
                    // Stuffed pair 0xFF 0x00 stands for a literal 0xFF
                    emit        = 1'b1;
                    emit_byte   = 8'hFF;
                    state_after = NORMAL;
                end else if (cur_byte == 8'hFF) begin
                    // Fill byte: stay waiting for the marker code
                    state_after = SAW_FF;
                end else begin
                    emit        = 1'b1;
                    emit_marker = 1'b1;
                    state_after = NORMAL;
                end
            end
            default: begin
                state_after = NORMAL;
            end
        endcase
    end

    // Next-state for buffer, pointer, FSM and output register
    always_comb begin
        word_d       = word_q;
        idx_d        = idx_q;
        buf_valid_d  = buf_valid_q;
        state_d      = state_q;
        out_byte_d   = out_byte_q;
        out_marker_d = out_marker_q;
        out_valid_d  = out_valid_q;

        if (consume) begin
            state_d = state_after;
            if (last_byte) begin
                buf_valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        // A capture overrides the end-of-word clear on the same edge
        if (accept) begin
            word_d      = in_data;
            idx_d       = 2'd0;
            buf_valid_d = 1'b1;
        end

        if (advance) begin
            out_valid_d = consume && emit;
            if (consume && emit) begin
                out_byte_d   = emit_byte;
                out_marker_d = emit_marker;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q       <= '0;
            idx_q        <= '0;
            buf_valid_q  <= 1'b0;
            state_q      <= NORMAL;
            out_byte_q   <= '0;
            out_marker_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            word_q       <= word_d;
            idx_q        <= idx_d;
            buf_valid_q  <= buf_valid_d;
            state_q      <= state_d;
            out_byte_q   <= out_byte_d;
            out_marker_q <= out_marker_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_byte   = out_byte_q;
    assign out_marker = out_marker_q;
    assign out_valid  = out_valid_q;

endmodule
